dmem_resp: RTL and testbench

Data-memory responder for the pipelined MIPS CPU: the memory-side end of the MEM stage's data-memory interface. It accepts byte-addressed load/store requests in the data segment starting at `32'h10010000` and converts them to word indices. It performs word, halfword and byte accesses, using an internal read-modify-write for sub-word stores. Load data is returned one cycle after the request, sign- or zero-extended, and requests to misaligned or out-of-range addresses are flagged.

---
 rtl/dmem_resp.sv | 170 +++++++++++++++++
 tb/tb_dmem_resp.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// dmem_resp
// Memory-side responder for the MEM stage data-memory interface of the
// pipelined MIPS CPU. Byte addresses in the data segment starting at
// BASE_ADDR are mapped to a DEPTH-word array. Word, halfword and byte
// loads/stores are supported; sub-word stores use a two-cycle
// read-modify-write. Load data is returned one cycle after acceptance,
// sign- or zero-extended. Misaligned, out-of-range or reserved-size
// requests are rejected and flagged with out_err.
//
// Ports
//   in_clk     clock, rising edge
//   in_rst     synchronous active-high reset
//   in_req     request valid (sampled only while out_ready=1)
//   in_wena    1 = store, 0 = load
//   in_type    00 word, 01 halfword, 10 byte, 11 reserved (error)
//   in_sign    loads: 1 sign-extend, 0 zero-extend
//   in_addr    byte address
//   in_wdata   store data, sub-word value in the low bits
//   out_ready  request can be accepted this cycle
//   out_rvalid one-cycle pulse, out_rdata holds the load result
//   out_rdata  extended load data, held between pulses
//   out_err    one-cycle pulse for a rejected request
module dmem_resp #(
  parameter logic [31:0] BASE_ADDR = 32'h10010000,
  parameter int          DEPTH     = 1024
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_req,
  input  logic        in_wena,
  input  logic [1:0]  in_type,
  input  logic        in_sign,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_ready,
  output logic        out_rvalid,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RMW  = 1'b1;

  localparam logic [1:0] T_WORD = 2'b00;
  localparam logic [1:0] T_HALF = 2'b01;
  localparam logic [1:0] T_BYTE = 2'b10;

  // Insert the low halfword/byte of wdata into the selected lane of old.
  function automatic logic [31:0] merge_lane(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [1:0]  typ,
    input logic [1:0]  lane
  );
    logic [31:0] res;
    res = old;
    if (typ == T_HALF) begin
      if (lane[1]) res[31:16] = wdata[15:0];
      else         res[15:0]  = wdata[15:0];
    end else begin
      res[{lane, 3'b000} +: 8] = wdata[7:0];
    end
    return res;
  endfunction

  // Select the addressed lane and extend it to 32 bits.
  function automatic logic [31:0] extend_lane(
    input logic [31:0] word,
    input logic [1:0]  typ,
    input logic [1:0]  lane,
    input logic        sgn
  );
    logic [15:0] half;
    logic [7:0]  byt;
    logic [31:0] res;
    half = lane[1] ? word[31:16] : word[15:0];
    byt  = word[{lane, 3'b000} +: 8];
    case (typ)
      T_HALF:  res = {{16{sgn & half[15]}}, half};
      T_BYTE:  res = {{24{sgn & byt[7]}}, byt};
      default: res = word;
    endcase
    return res;
  endfunction

  logic [31:0] mem [DEPTH];

  logic [0:0]        state;
  logic [ADDR_W-1:0] hold_idx_p1;
  logic [1:0]        hold_lane_p1;
  logic [1:0]        hold_type_p1;
  logic [31:0]       hold_data_p1;
  logic [31:0]       hold_word_p1;

  logic [31:0]       off;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic              misalign;
  logic              bad;
  logic              accept;
  logic [31:0]       rd_word;

  // Request decode (combinational, before the accepting edge)
  always_comb begin
    off          = in_addr - BASE_ADDR;
    idx          = off[ADDR_W+1:2];
    lane         = off[1:0];
    // Addresses below the base wrap to huge offsets and fail here too.
    out_of_range = (off >> (ADDR_W + 2)) != 32'd0;
    misalign     = 1'b0;
    case (in_type)
      T_WORD:  misalign = (off[1:0] != 2'b00);
      T_HALF:  misalign = off[0];
      default: misalign = 1'b0;
    endcase
    bad     = out_of_range | misalign | (in_type == 2'b11);
    accept  = in_req & (state == IDLE);
    rd_word = mem[idx];
  end

  assign out_ready = (state == IDLE);

  // Array write port: word stores at acceptance, sub-word merges in RMW.
  // Reset suppresses both, so a pending merge is discarded.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      if (state == RMW)
        mem[hold_idx_p1] <= merge_lane(hold_word_p1, hold_data_p1, hold_type_p1, hold_lane_p1);
      else if (accept && in_wena && !bad && (in_type == T_WORD))
        mem[idx] <= in_wdata;
    end
  end

  // Control, response and holding registers
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state        <= IDLE;
      out_rvalid   <= 1'b0;
      out_err      <= 1'b0;
      out_rdata    <= 32'd0;
      hold_idx_p1  <= '0;
      hold_lane_p1 <= 2'b00;
      hold_type_p1 <= 2'b00;
      hold_data_p1 <= 32'd0;
      hold_word_p1 <= 32'd0;
    end else begin
      out_rvalid <= accept & ~in_wena;
      out_err    <= accept & bad;
      if (accept && !in_wena)
        out_rdata <= bad ? 32'd0 : extend_lane(rd_word, in_type, lane, in_sign);
      case (state)
        IDLE: begin
          if (accept && in_wena && !bad && (in_type != T_WORD)) begin
            hold_idx_p1  <= idx;
            hold_lane_p1 <= lane;
            hold_type_p1 <= in_type;
            hold_data_p1 <= in_wdata;
            hold_word_p1 <= rd_word;
            state        <= RMW;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_req;
  logic        in_wena;
  logic [1:0]  in_type;
  logic        in_sign;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        out_ready;
  logic        out_rvalid;
  logic [31:0] out_rdata;
  logic        out_err;

  int n_vec = 0;
  int n_bad = 0;

  dmem_resp #(.BASE_ADDR(32'h10010000), .DEPTH(1024)) dut (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_req    (in_req),
    .in_wena   (in_wena),
    .in_type   (in_type),
    .in_sign   (in_sign),
    .in_addr   (in_addr),
    .in_wdata  (in_wdata),
    .out_ready (out_ready),
    .out_rvalid(out_rvalid),
    .out_rdata (out_rdata),
    .out_err   (out_err)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at the falling edge, wait (bounded) for out_ready,
  // let it be accepted at the next rising edge; returns at edge + 1.
  task automatic issue(input logic wena, input logic [1:0] typ, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge in_clk);
    in_req = 1'b1; in_wena = wena; in_type = typ; in_sign = sgn;
    in_addr = addr; in_wdata = wdata;
    n = 0;
    while (!out_ready && n < 8) begin
      @(negedge in_clk);
      n++;
    end
    if (n == 8) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge in_clk);
    #1;
    in_req = 1'b0;
  endtask

  task automatic load(input string tag, input logic [1:0] typ, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] exp);
    issue(1'b0, typ, sgn, addr, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, out_rvalid}, 32'd1);
    chk({tag, "_err"},    {31'd0, out_err},    32'd0);
    chk({tag, "_rdata"},  out_rdata,           exp);
  endtask

  task automatic bad_load(input string tag, input logic [1:0] typ, input logic [31:0] addr);
    issue(1'b0, typ, 1'b0, addr, 32'd0);
    chk({tag, "_err"},    {31'd0, out_err},    32'd1);
    chk({tag, "_rvalid"}, {31'd0, out_rvalid}, 32'd1);
    chk({tag, "_rdata"},  out_rdata,           32'd0);
  endtask

  task automatic bad_store(input string tag, input logic [1:0] typ, input logic [31:0] addr);
    issue(1'b1, typ, 1'b0, addr, 32'hFFFFFFFF);
    chk({tag, "_err"},    {31'd0, out_err},    32'd1);
    chk({tag, "_rvalid"}, {31'd0, out_rvalid}, 32'd0);
    chk({tag, "_ready"},  {31'd0, out_ready},  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_rst = 1'b1; in_req = 1'b0; in_wena = 1'b0; in_type = 2'b00;
    in_sign = 1'b0; in_addr = 32'd0; in_wdata = 32'd0;
    repeat (2) @(posedge in_clk);
    #1;
    chk("rst_ready",  {31'd0, out_ready},  32'd1);
    chk("rst_rvalid", {31'd0, out_rvalid}, 32'd0);
    chk("rst_err",    {31'd0, out_err},    32'd0);
    chk("rst_rdata",  out_rdata,           32'd0);
    @(negedge in_clk);
    in_rst = 1'b0;

    // Word store then word load
    issue(1'b1, 2'b00, 1'b0, 32'h10010004, 32'hDEADBEEF);
    chk("sw_ready",  {31'd0, out_ready},  32'd1);
    chk("sw_rvalid", {31'd0, out_rvalid}, 32'd0);
    load("lw1", 2'b00, 1'b0, 32'h10010004, 32'hDEADBEEF);
    chk("lw1_ready", {31'd0, out_ready}, 32'd1);
    @(posedge in_clk); #1;
    chk("idle_rvalid", {31'd0, out_rvalid}, 32'd0);
    chk("idle_hold",   out_rdata,           32'hDEADBEEF);

    // Byte store with one-cycle RMW
    issue(1'b1, 2'b10, 1'b0, 32'h10010005, 32'h00000080);
    chk("sb_ready_lo", {31'd0, out_ready}, 32'd0);
    @(posedge in_clk); #1;
    chk("sb_ready_hi", {31'd0, out_ready}, 32'd1);
    load("lb",  2'b10, 1'b1, 32'h10010005, 32'hFFFFFF80);
    load("lbu", 2'b10, 1'b0, 32'h10010005, 32'h00000080);
    load("lw2", 2'b00, 1'b0, 32'h10010004, 32'hDEAD80EF);

    // Halfword store over a zeroed word
    issue(1'b1, 2'b00, 1'b0, 32'h10010008, 32'h00000000);
    issue(1'b1, 2'b01, 1'b0, 32'h1001000A, 32'hABCD1234);
    load("lw3", 2'b00, 1'b0, 32'h10010008, 32'h12340000);
    load("lh",  2'b01, 1'b1, 32'h1001000A, 32'h00001234);

    // Known values at the edge words to catch wrapped/out-of-range writes
    issue(1'b1, 2'b00, 1'b0, 32'h10010000, 32'h11111111);
    issue(1'b1, 2'b00, 1'b0, 32'h10010FFC, 32'h22222222);

    // Rejected loads
    bad_load("e_lw_mis", 2'b00, 32'h10010002);
    bad_load("e_lh_mis", 2'b01, 32'h10010001);
    bad_load("e_type3",  2'b11, 32'h10010008);
    bad_load("e_below",  2'b00, 32'h1000FFFC);
    bad_load("e_above",  2'b00, 32'h10011000);
    @(posedge in_clk); #1;
    chk("e_err_clear", {31'd0, out_err}, 32'd0);

    // Rejected stores leave memory unchanged
    bad_store("s_sw_mis", 2'b00, 32'h10010006);
    bad_store("s_sh_mis", 2'b01, 32'h10010005);
    bad_store("s_type3",  2'b11, 32'h10010008);
    bad_store("s_below",  2'b00, 32'h1000FFFC);
    bad_store("s_above",  2'b00, 32'h10011000);
    load("chk_w1",    2'b00, 1'b0, 32'h10010004, 32'hDEAD80EF);
    load("chk_w2",    2'b00, 1'b0, 32'h10010008, 32'h12340000);
    load("chk_w0",    2'b00, 1'b0, 32'h10010000, 32'h11111111);
    load("chk_wlast", 2'b00, 1'b0, 32'h10010FFC, 32'h22222222);

    // Byte store followed by a held load, then back-to-back loads
    @(negedge in_clk);
    in_req = 1'b1; in_wena = 1'b1; in_type = 2'b10; in_sign = 1'b0;
    in_addr = 32'h10010006; in_wdata = 32'h0000005A;
    @(negedge in_clk);
    chk("hold_ready_lo", {31'd0, out_ready}, 32'd0);
    in_wena = 1'b0; in_type = 2'b00; in_addr = 32'h10010004; in_wdata = 32'd0;
    @(posedge in_clk); #1;
    chk("hold_rvalid_lo", {31'd0, out_rvalid}, 32'd0);
    chk("hold_ready_hi",  {31'd0, out_ready},  32'd1);
    @(posedge in_clk); #1;
    chk("b2b1_rvalid", {31'd0, out_rvalid}, 32'd1);
    chk("b2b1_rdata",  out_rdata,           32'hDE5A80EF);
    in_type = 2'b10; in_sign = 1'b0; in_addr = 32'h10010006;
    @(posedge in_clk); #1;
    chk("b2b2_rvalid", {31'd0, out_rvalid}, 32'd1);
    chk("b2b2_rdata",  out_rdata,           32'h0000005A);
    in_sign = 1'b1; in_addr = 32'h10010007;
    @(posedge in_clk); #1;
    chk("b2b3_rvalid", {31'd0, out_rvalid}, 32'd1);
    chk("b2b3_rdata",  out_rdata,           32'hFFFFFFDE);
    in_req = 1'b0;
    @(posedge in_clk); #1;
    chk("b2b_end_rvalid", {31'd0, out_rvalid}, 32'd0);

    // Reset during RMW discards the merge
    issue(1'b1, 2'b10, 1'b0, 32'h10010004, 32'h00000077);
    chk("rr_ready_lo", {31'd0, out_ready}, 32'd0);
    in_rst = 1'b1;
    @(posedge in_clk); #1;
    chk("rr_ready",  {31'd0, out_ready},  32'd1);
    chk("rr_rvalid", {31'd0, out_rvalid}, 32'd0);
    chk("rr_err",    {31'd0, out_err},    32'd0);
    chk("rr_rdata",  out_rdata,           32'd0);
    @(negedge in_clk);
    in_rst = 1'b0;
    load("rr_lw", 2'b00, 1'b0, 32'h10010004, 32'hDE5A80EF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
